// File: rtl/serving_mem_arbiter.sv
// Round-robin arbiter sharing the SRAM Wishbone port between ibus, dbus and ext masters.
// Request in IDLE at cycle N drives o_wb_stb from N+1. Losers wait, and a silent slave is aborted after TIMEOUT BUSY cycles.
module serving_mem_arbiter #(
    parameter int aw      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [aw-3:0] i_ibus_adr,
    input  logic          i_ibus_stb,
    output logic          o_ibus_ack,
    output logic          o_ibus_err,
    input  logic [aw-3:0] i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_stb,
    output logic          o_dbus_ack,
    output logic          o_dbus_err,
    input  logic [aw-3:0] i_ext_adr,
    input  logic [31:0]   i_ext_dat,
    input  logic [3:0]    i_ext_sel,
    input  logic          i_ext_we,
    input  logic          i_ext_stb,
    output logic          o_ext_ack,
    output logic          o_ext_err,
    output logic [31:0]   o_rdt,
    output logic [aw-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic [1:0]    o_grant,
    output logic          o_busy
);
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [7:0]      timer_q, timer_d;
    logic [aw-3:0]   adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            stb_q, stb_d;
    logic [2:0]      req;
    logic [1:0]      win;

    assign req = {i_ext_stb, i_dbus_stb, i_ibus_stb};

    // Search starts just after the last grantee so every requester waits at most two transactions.
    always_comb begin
        win = 2'd0;
        case (grant_q)
            2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        timer_d = timer_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        stb_d   = stb_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    grant_d = win;
                    timer_d = 8'd0;
                    stb_d   = 1'b1;
                    case (win)
                        2'd0: begin
                            adr_d = i_ibus_adr;
                            dat_d = 32'd0;
                            sel_d = 4'hf;
                            we_d  = 1'b0;
                        end
                        2'd1: begin
                            adr_d = i_dbus_adr;
                            dat_d = i_dbus_dat;
                            sel_d = i_dbus_sel;
                            we_d  = i_dbus_we;
                        end
                        default: begin
                            adr_d = i_ext_adr;
                            dat_d = i_ext_dat;
                            sel_d = i_ext_sel;
                            we_d  = i_ext_we;
                        end
                    endcase
                end
            end
            BUSY: begin
                // A late ack in the final timer cycle still completes the transfer.
                if (i_wb_ack) begin
                    stb_d   = 1'b0;
                    state_d = IDLE;
                end else if (timer_q == TMO_LAST) begin
                    stb_d   = 1'b0;
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'd2;
            timer_q <= 8'd0;
            adr_q   <= '0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            timer_q <= timer_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
        end
    end

    logic ack_vld, err_vld;
    assign ack_vld = (state_q == BUSY) && i_wb_ack;
    assign err_vld = (state_q == ERR);

    assign o_ibus_ack = ack_vld && (grant_q == 2'd0);
    assign o_dbus_ack = ack_vld && (grant_q == 2'd1);
    assign o_ext_ack  = ack_vld && (grant_q == 2'd2);
    assign o_ibus_err = err_vld && (grant_q == 2'd0);
    assign o_dbus_err = err_vld && (grant_q == 2'd1);
    assign o_ext_err  = err_vld && (grant_q == 2'd2);

    assign o_rdt    = i_wb_rdt;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;
    assign o_wb_we  = we_q;
    assign o_wb_stb = stb_q;
    assign o_grant  = grant_q;
    assign o_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_serving_mem_arbiter.sv
// Directed bench for serving_mem_arbiter with a small SRAM slave model (4-cycle ack, RF-write stall).
module tb_serving_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  ibus_adr = '0;
    logic        ibus_stb = 1'b0;
    logic        ibus_ack, ibus_err;
    logic [5:0]  dbus_adr = '0;
    logic [31:0] dbus_dat = '0;
    logic [3:0]  dbus_sel = '0;
    logic        dbus_we = 1'b0;
    logic        dbus_stb = 1'b0;
    logic        dbus_ack, dbus_err;
    logic [5:0]  ext_adr = '0;
    logic [31:0] ext_dat = '0;
    logic [3:0]  ext_sel = '0;
    logic        ext_we = 1'b0;
    logic        ext_stb = 1'b0;
    logic        ext_ack, ext_err;
    logic [31:0] rdt;
    logic [5:0]  wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic [1:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // SRAM model: acks on its 4th non-stalled stb cycle; wen stalls the byte counter.
    logic [31:0] mem [0:63];
    int          cnt = 0;
    logic        wen = 1'b0;
    logic        ack_mode = 1'b0;
    logic        ack_force = 1'b0;
    logic        pl_we = 1'b0;
    logic [5:0]  pl_adr = '0;
    logic [31:0] pl_dat = '0;
    logic        model_ack;

    assign model_ack = wb_stb && (cnt == 3) && !wen;
    assign wb_ack    = ack_mode ? ack_force : model_ack;
    assign wb_rdt    = mem[wb_adr];

    always @(posedge clk) begin
        if (!wb_stb || wb_ack) cnt <= 0;
        else if (!wen) cnt <= cnt + 1;
        if (pl_we) mem[pl_adr] <= pl_dat;
        else if (wb_ack && wb_we && wb_stb) begin
            for (int b = 0; b < 4; b++)
                if (wb_sel[b]) mem[wb_adr][8*b +: 8] <= wb_dat[8*b +: 8];
        end
    end

    always #5 clk = ~clk;

    serving_mem_arbiter #(.aw(8), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ibus_adr(ibus_adr), .i_ibus_stb(ibus_stb), .o_ibus_ack(ibus_ack), .o_ibus_err(ibus_err),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
        .i_dbus_stb(dbus_stb), .o_dbus_ack(dbus_ack), .o_dbus_err(dbus_err),
        .i_ext_adr(ext_adr), .i_ext_dat(ext_dat), .i_ext_sel(ext_sel), .i_ext_we(ext_we),
        .i_ext_stb(ext_stb), .o_ext_ack(ext_ack), .o_ext_err(ext_err),
        .o_rdt(rdt),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_stb(wb_stb),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
        .o_grant(grant), .o_busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pl_adr = a; pl_dat = d; pl_we = 1'b1;
        tick();
        pl_we = 1'b0;
    endtask

    // resp bits: {ext_err, dbus_err, ibus_err, ext_ack, dbus_ack, ibus_ack}
    task automatic wait_resp(output int cyc, output logic [5:0] resp, output logic [31:0] d);
        cyc = 0;
        resp = '0;
        while (resp == 6'd0 && cyc < 40) begin
            tick();
            cyc++;
            resp = {ext_err, dbus_err, ibus_err, ext_ack, dbus_ack, ibus_ack};
        end
        d = rdt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b exp 0", wb_stb); end
        checks++; if (grant !== 2'd2) begin errors++; $display("FAIL reset_grant got %0d exp 2", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({wb_adr, wb_dat, wb_sel, wb_we} !== 43'd0) begin errors++; $display("FAIL reset_wb_regs got %h/%h/%h/%b exp 0", wb_adr, wb_dat, wb_sel, wb_we); end
        checks++; if ({ibus_ack, dbus_ack, ext_ack, ibus_err, dbus_err, ext_err} !== 6'd0) begin errors++; $display("FAIL reset_resp got nonzero ack/err exp 0"); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ibus_read();
        preload(6'h05, 32'hDEADBEEF);
        ibus_adr = 6'h05; ibus_stb = 1'b1;
        tick();
        checks++; if (wb_stb !== 1'b1) begin errors++; $display("FAIL ibus_stb_rise got %b exp 1", wb_stb); end
        checks++; if ({wb_adr, wb_sel, wb_we, wb_dat} !== {6'h05, 4'hf, 1'b0, 32'd0}) begin errors++; $display("FAIL ibus_req got adr %h sel %h we %b dat %h exp 05/f/0/0", wb_adr, wb_sel, wb_we, wb_dat); end
        checks++; if (grant !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL ibus_grant got %0d busy %b exp 0 busy 1", grant, busy); end
        tick(); tick();
        checks++; if (ibus_ack !== 1'b0) begin errors++; $display("FAIL ibus_early_ack got %b exp 0", ibus_ack); end
        tick();
        checks++; if (ibus_ack !== 1'b1 || rdt !== 32'hDEADBEEF) begin errors++; $display("FAIL ibus_ack_n4 got ack %b rdt %h exp 1 deadbeef", ibus_ack, rdt); end
        checks++; if ({dbus_ack, ext_ack} !== 2'b00) begin errors++; $display("FAIL ibus_other_ack got %b exp 00", {dbus_ack, ext_ack}); end
        ibus_stb = 1'b0;
        tick();
        checks++; if (wb_stb !== 1'b0 || busy !== 1'b0 || ibus_ack !== 1'b0) begin errors++; $display("FAIL ibus_idle got stb %b busy %b ack %b exp 0 0 0", wb_stb, busy, ibus_ack); end
    endtask

    task automatic test_dbus_write_merge();
        int c; logic [5:0] r; logic [31:0] d;
        preload(6'h03, 32'hAABBCCDD);
        dbus_adr = 6'h03; dbus_dat = 32'h11223344; dbus_sel = 4'b0101; dbus_we = 1'b1; dbus_stb = 1'b1;
        wait_resp(c, r, d);
        checks++; if (c !== 4 || r !== 6'b000010) begin errors++; $display("FAIL dbus_write_ack got cyc %0d resp %b exp 4 000010", c, r); end
        checks++; if (grant !== 2'd1) begin errors++; $display("FAIL dbus_write_grant got %0d exp 1", grant); end
        dbus_stb = 1'b0; dbus_we = 1'b0;
        tick();
        ibus_adr = 6'h03; ibus_stb = 1'b1;
        wait_resp(c, r, d);
        checks++; if (r !== 6'b000001 || d !== 32'hAA22CC44) begin errors++; $display("FAIL dbus_merge_read got resp %b rdt %h exp 000001 aa22cc44", r, d); end
        ibus_stb = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int c; logic [5:0] r; logic [31:0] d;
        logic [1:0] exp_g [0:5];
        exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2;
        exp_g[3] = 2'd0; exp_g[4] = 2'd1; exp_g[5] = 2'd2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ibus_adr = 6'h01; dbus_adr = 6'h02; dbus_we = 1'b0; dbus_sel = 4'hf;
        ext_adr = 6'h04; ext_we = 1'b0; ext_sel = 4'hf;
        ibus_stb = 1'b1; dbus_stb = 1'b1; ext_stb = 1'b1;
        for (int t = 0; t < 6; t++) begin
            wait_resp(c, r, d);
            checks++; if (grant !== exp_g[t] || r !== (6'd1 << exp_g[t])) begin errors++; $display("FAIL rr_grant[%0d] got grant %0d resp %b exp %0d", t, grant, r, exp_g[t]); end
            checks++; if (c !== 4) begin errors++; $display("FAIL rr_latency[%0d] got %0d exp 4", t, c); end
            tick();
            checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d] got stb %b exp 0", t, wb_stb); end
        end
        ibus_stb = 1'b0; dbus_stb = 1'b0; ext_stb = 1'b0;
        tick(); tick();
    endtask

    task automatic test_rf_stall();
        int c; logic [5:0] r; logic [31:0] d;
        dbus_adr = 6'h07; dbus_dat = 32'hCAFEF00D; dbus_sel = 4'hf; dbus_we = 1'b1; dbus_stb = 1'b1;
        tick();
        tick(); wen = 1'b1;
        tick();
        tick();
        checks++; if (dbus_ack !== 1'b0 || wb_stb !== 1'b1) begin errors++; $display("FAIL stall_no_ack got ack %b stb %b exp 0 1", dbus_ack, wb_stb); end
        tick(); wen = 1'b0;
        wait_resp(c, r, d);
        checks++; if (c !== 2 || r !== 6'b000010) begin errors++; $display("FAIL stall_ack got %0d cycles after stall resp %b exp 2 000010", c, r); end
        dbus_stb = 1'b0; dbus_we = 1'b0;
        tick();
        ibus_adr = 6'h07; ibus_stb = 1'b1;
        wait_resp(c, r, d);
        checks++; if (d !== 32'hCAFEF00D || c !== 4) begin errors++; $display("FAIL stall_data got rdt %h cyc %0d exp cafef00d 4", d, c); end
        ibus_stb = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int c; logic [5:0] r; logic [31:0] d;
        ack_mode = 1'b1; ack_force = 1'b0;
        dbus_adr = 6'h09; dbus_we = 1'b0; dbus_stb = 1'b1;
        wait_resp(c, r, d);
        checks++; if (c !== 9 || r !== 6'b010000) begin errors++; $display("FAIL timeout_err got cyc %0d resp %b exp 9 010000", c, r); end
        checks++; if (wb_stb !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_err_state got stb %b busy %b exp 0 1", wb_stb, busy); end
        dbus_stb = 1'b0;
        tick();
        checks++; if (dbus_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_err_pulse got err %b busy %b exp 0 0", dbus_err, busy); end
        ack_mode = 1'b0;
        ibus_adr = 6'h05; ibus_stb = 1'b1;
        wait_resp(c, r, d);
        checks++; if (c !== 4 || r !== 6'b000001 || d !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_recover got cyc %0d resp %b rdt %h exp 4 000001 deadbeef", c, r, d); end
        ibus_stb = 1'b0;
        tick();
        // Ack lands in the final allowed BUSY cycle.
        ack_mode = 1'b1; ack_force = 1'b0;
        dbus_stb = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        checks++; if (wb_stb !== 1'b1 || dbus_ack !== 1'b0 || dbus_err !== 1'b0) begin errors++; $display("FAIL late_pre got stb %b ack %b err %b exp 1 0 0", wb_stb, dbus_ack, dbus_err); end
        ack_force = 1'b1;
        #1;
        checks++; if (dbus_ack !== 1'b1 || dbus_err !== 1'b0) begin errors++; $display("FAIL late_ack got ack %b err %b exp 1 0", dbus_ack, dbus_err); end
        dbus_stb = 1'b0;
        tick();
        checks++; if (dbus_ack !== 1'b0 || dbus_err !== 1'b0 || busy !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL late_after got ack %b err %b busy %b stb %b exp 0 0 0 0", dbus_ack, dbus_err, busy, wb_stb); end
        ack_force = 1'b0; ack_mode = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int c; logic [5:0] r; logic [31:0] d;
        dbus_adr = 6'h05; dbus_we = 1'b0; dbus_stb = 1'b1;
        tick(); tick();
        checks++; if (wb_stb !== 1'b1 || grant !== 2'd1) begin errors++; $display("FAIL arst_pre got stb %b grant %0d exp 1 1", wb_stb, grant); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wb_stb !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_async got stb %b busy %b exp 0 0", wb_stb, busy); end
        checks++; if (grant !== 2'd2 || dbus_ack !== 1'b0 || dbus_err !== 1'b0) begin errors++; $display("FAIL arst_grant got grant %0d ack %b err %b exp 2 0 0", grant, dbus_ack, dbus_err); end
        dbus_stb = 1'b0;
        tick();
        #3 rst_n = 1'b1;
        ibus_adr = 6'h05; ibus_stb = 1'b1; dbus_stb = 1'b1; ext_stb = 1'b1;
        wait_resp(c, r, d);
        checks++; if (grant !== 2'd0 || r !== 6'b000001) begin errors++; $display("FAIL arst_first_grant got grant %0d resp %b exp 0 000001", grant, r); end
        ibus_stb = 1'b0; dbus_stb = 1'b0; ext_stb = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ibus_read();
        test_dbus_write_merge();
        test_round_robin();
        test_rf_stall();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish");
        $fatal(1, "watchdog expired");
    end
endmodule
